pixel_plot_sink: RTL
====================

// Module: pixel_plot_sink
// PURPOSE
//  Receiving end of the pixel-plot interface (x, y, color, plot) driven by the character/text writers.
//  Buffers plot commands in a small FIFO, range-checks them, converts (x,y) to a linear framebuffer
//  address and issues one write per cycle to the framebuffer RAM port, honouring a memory stall.
//  Also provides a full-screen clear sweep that writes 0 (black) to every pixel.
// PARAMETERS
//  H_RES       640  horizontal pixels; valid x = 0..H_RES-1
//  V_RES       480  vertical pixels; valid y = 0..V_RES-1
//  COLOR_W     3    bits per pixel
//  FIFO_DEPTH  8    command FIFO entries; power of 2, >= 2
//  ADDR_W      19   framebuffer address width; 2**ADDR_W >= H_RES*V_RES
// PORTS
//  clock       in   1        system clock, all logic on rising edge
//  resetn      in   1        asynchronous, active-low reset
//  in_x        in   10       plot x coordinate
//  in_y        in   10       plot y coordinate
//  in_color    in   COLOR_W  plot color
//  plot        in   1        command valid
//  plot_ready  out  1        sink can accept; transfer when plot && plot_ready on a rising edge
//  fb_addr     out  ADDR_W   framebuffer write address = y*H_RES + x
//  fb_data     out  COLOR_W  framebuffer write data
//  fb_we       out  1        write request; RAM takes write on edge where fb_we && !fb_busy
//  fb_busy     in   1        RAM stall; while high, fb_addr/fb_data/fb_we held unchanged
//  clear_req   in   1        request full-screen clear (level sampled each edge)
//  clear_busy  out  1        high while clear pending or in progress
//  drop_count  out  16       count of rejected out-of-range commands, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: FIFO empty, output stage empty, state RUN, fb_we=0, fb_addr=0, fb_data=0, plot_ready=0
//   while resetn low, clear_busy=0, drop_count=0. Reset mid-operation discards queued pixels and
//   aborts any clear; no partial write is issued after reset release.
//  plot_ready = (state==RUN) && !fifo_full; combinational, no same-cycle push/pop bypass when full.
//  Accepted command with in_x>=H_RES or in_y>=V_RES: not enqueued, drop_count +1 (saturating).
//  Output stage: one register (fb_addr, fb_data, fb_we). Loads FIFO head when stage empty or
//   current write taken (fb_we && !fb_busy) and FIFO non-empty; else fb_we deasserts on take.
//  Latency: command accepted at edge N (FIFO empty, stage idle, fb_busy=0) -> fb_we=1 after edge N+1.
//  Throughput: one write per cycle while fb_busy=0; order strictly preserved.
//  Address math: y*H_RES + x computed at full ADDR_W width, no truncation for in-range inputs.
//  States: RUN -> (clear_req) CLR_DRAIN -> (FIFO empty && stage empty or taken) CLR_SWEEP -> RUN.
//   CLR_DRAIN: plot_ready=0, queued pixels still written in order.
//   CLR_SWEEP: stage writes addr 0..H_RES*V_RES-1, data 0, one per non-stalled cycle; after last
//    write taken -> RUN. clear_req during CLR_DRAIN/CLR_SWEEP ignored (no restart, no queueing).
//  clear_busy = (state != RUN). plot in same cycle as clear_req accepted if plot_ready was high.
// TESTING
//  1 plot (x=5,y=3,color=7) -> single write fb_addr=1925, fb_data=7, fb_we high exactly one cycle.
//  2 plot (x=640,y=0) then (x=0,y=480) -> no fb_we, drop_count=2; corners (639,479) -> addr 307199.
//  3 fb_busy=1, stream plots -> exactly 9 accepted, then plot_ready=0; release -> 9 writes in order.
//  4 queue 2 pixels, pulse clear_req -> 2 pixel writes, then 307200 writes addr 0..307199 data 0,
//    clear_busy low after last write, plot_ready high again.
//  5 random fb_busy toggling with 1000 plots -> write sequence equals accepted in-range sequence.
//  6 assert resetn mid-sweep at addr 1000 -> fb_we=0, clear_busy=0, drop_count=0, no further writes.

Source files
------------

// File: rtl/pixel_plot_sink.sv
// Pixel-plot receiver: queues plot commands, range-checks them and writes (y*H_RES+x, color)
// to the framebuffer one pixel per cycle; also sweeps the whole screen to black on request.
module pixel_plot_sink #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COLOR_W    = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 19
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [9:0]         in_x,
  input  logic [9:0]         in_y,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               plot,
  output logic               plot_ready,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               fb_we,
  input  logic               fb_busy,
  input  logic               clear_req,
  output logic               clear_busy,
  output logic [15:0]        drop_count
);

  // state     | meaning
  // RUN       | accepting plot commands
  // CLR_DRAIN | clear requested; no new commands, queued pixels still written
  // CLR_SWEEP | writing 0 to every pixel address in ascending order
  typedef enum logic [1:0] {RUN, CLR_DRAIN, CLR_SWEEP} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = ADDR_W + 1;
  localparam int ENT_W = ADDR_W + COLOR_W;
  localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(H_RES * V_RES);

  state_t               state, state_nxt;
  logic [ENT_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr, rd_ptr;
  logic                 fifo_empty, fifo_full;
  logic                 in_range, accept, push, pop, drop;
  logic                 take, stage_free, sweep_load;
  logic [ADDR_W-1:0]    plot_addr;
  logic [ENT_W-1:0]     head;
  logic [CNT_W-1:0]     sweep_cnt;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

  // resetn gates the handshake so nothing is accepted while the block is held in reset
  assign plot_ready = resetn && (state == RUN) && !fifo_full;
  assign clear_busy = (state != RUN);

  assign in_range  = (32'(in_x) < 32'(H_RES)) && (32'(in_y) < 32'(V_RES));
  assign plot_addr = ADDR_W'(in_y) * ADDR_W'(H_RES) + ADDR_W'(in_x);
  assign accept    = plot && plot_ready;
  assign push      = accept && in_range;
  assign drop      = accept && !in_range;

  assign take       = fb_we && !fb_busy;
  assign stage_free = !fb_we || take;
  assign sweep_load = (state == CLR_SWEEP) && stage_free && (sweep_cnt != PIX_TOTAL);
  assign pop        = stage_free && !fifo_empty && (state != CLR_SWEEP);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:       if (clear_req) state_nxt = CLR_DRAIN;
      CLR_DRAIN: if (fifo_empty && stage_free) state_nxt = CLR_SWEEP;
      CLR_SWEEP: if ((sweep_cnt == PIX_TOTAL) && stage_free) state_nxt = RUN;
      default:   state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= RUN;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {plot_addr, in_color};
  end

  // Single output register; it only changes when empty or when the RAM takes the current write.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else if (sweep_load) begin
      fb_we   <= 1'b1;
      fb_addr <= sweep_cnt[ADDR_W-1:0];
      fb_data <= '0;
    end else if (pop) begin
      fb_we   <= 1'b1;
      fb_addr <= head[ENT_W-1:COLOR_W];
      fb_data <= head[COLOR_W-1:0];
    end else if (take) begin
      fb_we   <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                 sweep_cnt <= '0;
    else if (state != CLR_SWEEP) sweep_cnt <= '0;
    else if (sweep_load)         sweep_cnt <= sweep_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                             drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end

endmodule
